seq_10110_gen: RTL and testbench
================================

Name: seq_10110_gen

Overview:
Serial pattern transmitter that drives the 10110 sequence onto a single-bit line, one bit per clock. It is the generating end of the 10110 sequence-detector interface and feeds the detector's in_seq directly. Each burst emits a requested number of patterns, with the patterns either overlapped or separated by a gap. An exp_det strobe marks each cycle in which a correct overlapping Mealy detector must assert its output.

Parameters:
- CW, 8, width of the pattern-count input and the internal pattern counter.
- GAP, 2, number of '0' gap bits inserted between patterns in non-overlap mode (0 allowed).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  burst request; sampled only in IDLE.
- count  input  CW  number of patterns in the burst; captured with start.
- ovl  input  1  1 = overlapped stream, 0 = gapped stream; captured with start.
- out_seq  output  1  serial data bit.
- out_vld  output  1  high while out_seq carries burst data (pattern or gap).
- exp_det  output  1  high in the cycle the final '0' of a pattern is on out_seq.
- busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive.
- done  output  1  one-cycle pulse at end of burst.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; all counters 0; out_seq, out_vld, exp_det, busy and done all 0 immediately. No partial pattern resumes after reset is released.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States:
  - IDLE: wait for start.
  - SEND: emit pattern bits; a 3-bit bit index selects the bit.
  - GAP: emit gap zeros; a gap counter runs.
  - FIN: one cycle, done=1.
- IDLE and start=1 at edge T:
  - Capture count and ovl.
  - If count=0: go to FIN. At T+1, done=1 and busy=1, and no bits are sent.
  - Otherwise: go to SEND. At T+1, out_vld=1 and out_seq=1, the first bit.
- Pattern bits are sent MSB first: 1,0,1,1,0.
- The first pattern of a burst always sends all 5 bits.
- Overlap mode (ovl=1): each later pattern sends only the suffix 1,1,0, because the prefix "10" is shared with the previous pattern's tail. The stream is 10110 110 110 ...
  - Total cycles = 5 + 3(N-1).
- Gapped mode (ovl=0): after each pattern except the last, GAP cycles follow with out_vld=1 and out_seq=0. Each later pattern sends all 5 bits.
  - GAP=0 means patterns are sent back to back, with full 5 bits each.
  - Total cycles = 5N + GAP(N-1).
- exp_det=1 exactly on each pattern's final '0' bit, so there are N pulses per burst.
  - In gapped mode with GAP=0, the back-to-back stream 1011010110 contains only N detections, because the "10" overlap is not re-used. exp_det still marks only the final bits.
- After the last bit of the last pattern: FIN for 1 cycle with done=1, busy=1, out_vld=0 and out_seq=0; then IDLE.
- busy=0 in IDLE. start is ignored while busy, and count/ovl changes mid-burst have no effect.
- start is accepted in the cycle after FIN, so bursts can run back to back with a one-cycle bubble (out_vld=0).
- Pattern counter: CW bits, counts remaining patterns. count = 2^CW-1 must complete fully, with no wrap.
- out_seq=0 whenever out_vld=0.

Optional Feature:
- Macro SEQ_GEN_ERR_INJ_EN.
- With the macro defined:
  - Extra port inj_err  input  1, captured with start.
  - When the captured value is 1, the last pattern of the burst has its 4th transmitted bit of the 5-bit pattern forced to 0, giving 1,0,1,0,0.
    - In overlap mode with N>1 this is the 2nd bit of the suffix, giving 1,0,0.
  - exp_det stays 0 for that corrupted pattern. All other patterns are unaffected.
- Without the macro: no inj_err port, and the logic is absent.

Test Plan:
- Reset mid-burst: rst pulses during bit 3 of pattern 1 → all outputs 0 in the same cycle; after release the block stays IDLE with out_vld=0 until the next start.
- start, count=1, ovl=0 → out_seq 1,0,1,1,0 on cycles T+1..T+5; exp_det only at T+5; done at T+6.
- start, count=3, ovl=1 → 11 bits 10110110110; exp_det at bit positions 5, 8 and 11; done follows bit 11; the detector model's det_out matches exp_det cycle for cycle.
- start, count=2, ovl=0, GAP=2 → 10110 00 10110 with out_vld=1 throughout all 12 cycles; exactly 2 exp_det pulses.
- start with count=0 → done pulse at T+1, out_vld never asserted. A start during a burst is ignored, and count changes mid-burst do not alter the length.
- (SEQ_GEN_ERR_INJ_EN) start, count=2, ovl=1, inj_err=1 → stream 10110100; one exp_det pulse at bit 5; the detector model flags exactly one detection.

Source files
------------

// File: rtl/seq_10110_gen.sv
// Serial 10110 pattern generator: bursts of N patterns, overlapped or gapped, with exp_det strobe.
// Optional error injection on the last pattern when SEQ_GEN_ERR_INJ_EN is defined.
module seq_10110_gen #(
  parameter int CW  = 8,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          ovl,
`ifdef SEQ_GEN_ERR_INJ_EN
  input  logic          inj_err,
`endif
  output logic          out_seq,
  output logic          out_vld,
  output logic          exp_det,
  output logic          busy,
  output logic          done
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t        state_r;
  logic [2:0]    bit_idx_r;
  logic [GW-1:0] gap_cnt_r;
  logic [CW-1:0] pat_cnt_r;
  logic          ovl_r;
  logic          inj_act_s;
  logic          last_s;
  logic          corrupt_s;
  logic [2:0]    nxt_idx_s;

  // Pattern bit by index (MSB first); corrupt clears the 4th bit.
  function automatic logic pat_bit(input logic [2:0] idx, input logic corrupt);
    case (idx)
      3'd0:    pat_bit = 1'b1;
      3'd1:    pat_bit = 1'b0;
      3'd2:    pat_bit = 1'b1;
      3'd3:    pat_bit = ~corrupt;
      default: pat_bit = 1'b0;
    endcase
  endfunction

`ifdef SEQ_GEN_ERR_INJ_EN
  logic inj_r;

  // Capture the injection request with start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_r <= 1'b0;
    end else if (state_r == ST_IDLE && start) begin
      inj_r <= inj_err;
    end else begin
      inj_r <= inj_r;
    end
  end

  assign inj_act_s = inj_r;
`else
  assign inj_act_s = 1'b0;
`endif

  // Next bit index and whether the pattern in flight is the corrupted last one.
  always_comb begin
    nxt_idx_s = bit_idx_r + 3'd1;
    last_s    = (pat_cnt_r == CW'(1));
    corrupt_s = inj_act_s & last_s;
  end

  // Burst FSM with registered outputs; pat_cnt_r holds patterns remaining incl. the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_idx_r <= 3'd0;
      gap_cnt_r <= '0;
      pat_cnt_r <= '0;
      ovl_r     <= 1'b0;
      out_seq   <= 1'b0;
      out_vld   <= 1'b0;
      exp_det   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_seq <= 1'b0;
          out_vld <= 1'b0;
          exp_det <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            ovl_r     <= ovl;
            pat_cnt_r <= count;
            bit_idx_r <= 3'd0;
            gap_cnt_r <= '0;
            busy      <= 1'b1;
            if (count == '0) begin
              state_r <= ST_FIN;
              done    <= 1'b1;
            end else begin
              state_r <= ST_SEND;
              out_vld <= 1'b1;
              out_seq <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_SEND: begin
          if (bit_idx_r == 3'd4) begin
            exp_det <= 1'b0;
            if (last_s) begin
              state_r <= ST_FIN;
              done    <= 1'b1;
              out_vld <= 1'b0;
              out_seq <= 1'b0;
            end else begin
              pat_cnt_r <= pat_cnt_r - CW'(1);
              if (ovl_r) begin
                // Shared "10" prefix: resume at the suffix 1,1,0.
                bit_idx_r <= 3'd2;
                out_seq   <= 1'b1;
              end else if (GAP > 0) begin
                state_r   <= ST_GAP;
                gap_cnt_r <= '0;
                out_seq   <= 1'b0;
              end else begin
                bit_idx_r <= 3'd0;
                out_seq   <= 1'b1;
              end
            end
          end else begin
            bit_idx_r <= nxt_idx_s;
            out_seq   <= pat_bit(nxt_idx_s, corrupt_s);
            exp_det   <= (nxt_idx_s == 3'd4) & ~corrupt_s;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r   <= ST_SEND;
            bit_idx_r <= 3'd0;
            gap_cnt_r <= '0;
            out_seq   <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          out_vld <= 1'b0;
          out_seq <= 1'b0;
          exp_det <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          out_vld <= 1'b0;
          out_seq <= 1'b0;
          exp_det <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_10110_gen.sv
// Directed self-checking bench for seq_10110_gen with an overlapping 10110 detector model.
module tb_seq_10110_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] count;
  logic       ovl;
`ifdef SEQ_GEN_ERR_INJ_EN
  logic       inj_err;
`endif
  logic       out_seq, out_vld, exp_det, busy, done;

  int checks = 0;
  int errors = 0;

  seq_10110_gen #(.CW(8), .GAP(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .count   (count),
    .ovl     (ovl),
`ifdef SEQ_GEN_ERR_INJ_EN
    .inj_err (inj_err),
`endif
    .out_seq (out_seq),
    .out_vld (out_vld),
    .exp_det (exp_det),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference overlapping Mealy detector fed by out_seq.
  logic [3:0] hist;
  logic       det_model;
  always @(posedge clk or posedge rst) begin
    if (rst) hist <= 4'd0;
    else     hist <= {hist[2:0], out_seq};
  end
  assign det_model = ({hist, out_seq} == 5'b10110);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_burst(input string name, input logic [7:0] cnt, input logic o, input logic inj,
                           input logic [31:0] seq, input logic [31:0] det, input int len,
                           input logic disturb);
    @(negedge clk);
    chk({name, " idle_vld"}, {31'd0, out_vld}, 32'd0);
    chk({name, " idle_busy"}, {31'd0, busy}, 32'd0);
    start = 1'b1; count = cnt; ovl = o;
`ifdef SEQ_GEN_ERR_INJ_EN
    inj_err = inj;
`else
    if (inj) $display("note: inj ignored in default build");
`endif
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk($sformatf("%s seq[%0d]", name, i), {31'd0, out_seq}, {31'd0, seq[len-1-i]});
      chk($sformatf("%s vld[%0d]", name, i), {31'd0, out_vld}, 32'd1);
      chk($sformatf("%s det[%0d]", name, i), {31'd0, exp_det}, {31'd0, det[len-1-i]});
      chk($sformatf("%s model[%0d]", name, i), {31'd0, det_model}, {31'd0, det[len-1-i]});
      chk($sformatf("%s busy[%0d]", name, i), {30'd0, busy, done}, 32'd2);
      if (disturb && i == 2) begin start = 1'b1; count = 8'd7; ovl = ~o; end
      if (disturb && i == 3) start = 1'b0;
    end
    @(negedge clk);
    chk({name, " fin_done"}, {31'd0, done}, 32'd1);
    chk({name, " fin_busy"}, {31'd0, busy}, 32'd1);
    chk({name, " fin_vld"}, {30'd0, out_vld, out_seq}, 32'd0);
    chk({name, " fin_det"}, {31'd0, exp_det}, 32'd0);
  endtask

  initial begin
    int cyc, vld_cnt, pulses;
    rst = 1'b1; start = 1'b0; count = 8'd0; ovl = 1'b0;
`ifdef SEQ_GEN_ERR_INJ_EN
    inj_err = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_outs", {27'd0, out_seq, out_vld, exp_det, busy, done}, 32'd0);
    rst = 1'b0;

    run_burst("c1_gap", 8'd1, 1'b0, 1'b0, 32'b10110, 32'b00001, 5, 1'b0);
    run_burst("c3_ovl", 8'd3, 1'b1, 1'b0, 32'b10110110110, 32'b00001001001, 11, 1'b1);
    run_burst("c2_gap", 8'd2, 1'b0, 1'b0, 32'b101100010110, 32'b000010000001, 12, 1'b0);
    run_burst("c0", 8'd0, 1'b1, 1'b0, 32'd0, 32'd0, 0, 1'b0);
    run_burst("c2_ovl", 8'd2, 1'b1, 1'b0, 32'b10110110, 32'b00001001, 8, 1'b0);
`ifdef SEQ_GEN_ERR_INJ_EN
    run_burst("inj_ovl", 8'd2, 1'b1, 1'b1, 32'b10110100, 32'b00001000, 8, 1'b0);
    run_burst("after_inj", 8'd1, 1'b0, 1'b0, 32'b10110, 32'b00001, 5, 1'b0);
`endif

    // Maximum count, overlapped: 5 + 3*254 cycles and 255 detections.
    @(negedge clk);
    start = 1'b1; count = 8'd255; ovl = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; count = 8'd1;
    cyc = 0; vld_cnt = 0; pulses = 0;
    while (cyc < 1000) begin
      @(negedge clk);
      if (done) break;
      if (out_vld) vld_cnt++;
      if (exp_det) pulses++;
      cyc++;
    end
    chk("max_timeout", {31'd0, done}, 32'd1);
    chk("max_len", vld_cnt, 32'd767);
    chk("max_pulses", pulses, 32'd255);

    // Reset asserted while bit 3 of the first pattern is on the line.
    @(negedge clk);
    start = 1'b1; count = 8'd1; ovl = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_bit3", {30'd0, out_vld, out_seq}, 32'd3);
    #2 rst = 1'b1;
    #1 chk("mid_rst_outs", {27'd0, out_seq, out_vld, exp_det, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", {28'd0, out_vld, out_seq, busy, done}, 32'd0);
    end

    run_burst("post_rst", 8'd1, 1'b1, 1'b0, 32'b10110, 32'b00001, 5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
